// File: rtl/scr1_dmem_pkg.sv
// Shared encodings and byte-lane helpers for the SCR1 dmem to Wishbone bridge.
// Lane helpers are pure combinational functions used by the bridge datapath.
package scr1_dmem_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [1:0] RESP_IDLE  = 2'b00;
  localparam logic [1:0] RESP_OKAY  = 2'b01;
  localparam logic [1:0] RESP_ERROR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic req_legal(input logic [1:0] width, input logic [1:0] off);
    case (width)
      WIDTH_BYTE: req_legal = 1'b1;
      WIDTH_HALF: req_legal = ~off[0];
      WIDTH_WORD: req_legal = (off == 2'b00);
      default:    req_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] width, input logic [1:0] off);
    case (width)
      WIDTH_BYTE: lane_sel = 4'b0001 << off;
      WIDTH_HALF: lane_sel = 4'b0011 << off;
      default:    lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] width, input logic [31:0] wdata);
    case (width)
      WIDTH_BYTE: lane_wdata = {4{wdata[7:0]}};
      WIDTH_HALF: lane_wdata = {2{wdata[15:0]}};
      default:    lane_wdata = wdata;
    endcase
  endfunction

  // Right-justify the addressed lane(s) and zero-extend above the access width.
  function automatic logic [31:0] lane_rdata(input logic [1:0] width, input logic [1:0] off,
                                             input logic [31:0] dat);
    logic [31:0] shifted;
    shifted = dat >> {off, 3'b000};
    case (width)
      WIDTH_BYTE: lane_rdata = {24'b0, shifted[7:0]};
      WIDTH_HALF: lane_rdata = {16'b0, shifted[15:0]};
      default:    lane_rdata = shifted;
    endcase
  endfunction

endpackage

// File: rtl/scr1_dmem_wb_bridge.sv
// SCR1 dmem port to 32-bit Wishbone B4 classic master: one bus cycle per legal request,
// immediate error for illegal ones, optional timeout abort while waiting for termination.
module scr1_dmem_wb_bridge
  import scr1_dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        dmem_req_ack,
  input  logic        dmem_req,
  input  logic        dmem_cmd,
  input  logic [1:0]  dmem_width,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic [1:0]  dmem_resp,
  output logic [29:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW:0] TO_LIM = (CW + 1)'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [29:0]   adr_q, adr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   dat_q, dat_d;
  logic [1:0]    width_q, width_d;
  logic [1:0]    off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    resp_q, resp_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          accept;
  logic [CW:0]   cnt_inc;
  logic          tmo_hit;

  assign dmem_req_ack = (state_q != ST_BUS);
  assign accept       = dmem_req & dmem_req_ack;
  assign cnt_inc      = {1'b0, cnt_q} + (CW + 1)'(1);
  assign tmo_hit      = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    width_d = width_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    resp_d  = RESP_IDLE;
    rdata_d = '0;
    case (state_q)
      ST_BUS: begin
        // err outranks ack; ack outranks a timeout expiring in the same cycle
        if (wb_err_i) begin
          state_d = ST_RESP;
          cyc_d   = 1'b0;
          resp_d  = RESP_ERROR;
        end else if (wb_ack_i) begin
          state_d = ST_RESP;
          cyc_d   = 1'b0;
          resp_d  = RESP_OKAY;
          rdata_d = we_q ? 32'b0 : lane_rdata(width_q, off_q, wb_dat_i);
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          cyc_d   = 1'b0;
          resp_d  = RESP_ERROR;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          width_d = dmem_width;
          off_d   = dmem_addr[1:0];
          if (req_legal(dmem_width, dmem_addr[1:0])) begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            we_d    = dmem_cmd;
            adr_d   = dmem_addr[31:2];
            sel_d   = lane_sel(dmem_width, dmem_addr[1:0]);
            dat_d   = lane_wdata(dmem_width, dmem_wdata);
            cnt_d   = '0;
          end else begin
            state_d = ST_RESP;
            resp_d  = RESP_ERROR;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      width_q <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= RESP_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      width_q <= width_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_resp  = resp_q;
  assign dmem_rdata = rdata_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_sel_o   = sel_q;
  assign wb_dat_o   = dat_q;
  assign wb_cti_o   = 3'b000;
  assign wb_bte_o   = 2'b00;

endmodule
